// File: rtl/ddr3_rd_capture.sv
// DDR3 read-data capture: strobe framer plus {tag,last,data} output FIFO.
// Optional error counter enabled by defining DDR3_RDCAP_ERRCNT_EN.
module ddr3_rd_capture #(
   parameter int DW         = 32,
   parameter int FIFO_DEPTH = 8,
   parameter int MAX_BEATS  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [3:0]                    strobe_in,
   input  logic [DW-1:0]                 rd_data_in,
   output logic                          rd_valid,
   input  logic                          rd_ready,
   output logic [DW-1:0]                 rd_data,
   output logic                          rd_tag,
   output logic                          rd_last,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   output logic                          frame_err,
   input  logic                          err_clr,
   output logic [7:0]                    err_cnt
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(MAX_BEATS + 1);

   typedef enum logic {S_IDLE, S_BURST} state_t;

   logic s_valid, s_first, s_last, s_tag;
   assign s_valid = strobe_in[0];
   assign s_first = strobe_in[1];
   assign s_last  = strobe_in[2];
   assign s_tag   = strobe_in[3];

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          tag_q, tag_d;
   logic          push, push_tag, push_last, ferr;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      tag_d     = tag_q;
      push      = 1'b0;
      push_tag  = tag_q;
      push_last = 1'b0;
      ferr      = 1'b0;
      if (s_valid) begin
         if (s_first) begin
            // A first beat always (re)starts a burst; inside a burst it is a framing error.
            push      = 1'b1;
            tag_d     = s_tag;
            push_tag  = s_tag;
            push_last = s_last;
            ferr      = (state_q == S_BURST);
            if (s_last) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               state_d = S_BURST;
               cnt_d   = CW'(1);
            end
         end else if (state_q == S_BURST) begin
            push     = 1'b1;
            push_tag = tag_q;
            if (s_last) begin
               push_last = 1'b1;
               state_d   = S_IDLE;
               cnt_d     = '0;
            end else if ((cnt_q + CW'(1)) >= CW'(MAX_BEATS)) begin
               push_last = 1'b1;
               ferr      = 1'b1;
               state_d   = S_IDLE;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end else begin
            ferr = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         tag_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tag_q   <= tag_d;
      end
   end

   logic [DW+1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic          pop, full, wr_en, drop;
   logic          ovf_q, ovf_d, ferr_q, ferr_d;

   assign pop   = (level_q != '0) && rd_ready;
   assign full  = (level_q == (AW+1)'(FIFO_DEPTH));
   // A full buffer still takes a beat when the consumer frees a slot this cycle.
   assign wr_en = push && (!full || pop);
   assign drop  = push && full && !pop;

   always_comb begin
      wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d  = level_q;
      if (wr_en && !pop)      level_d = level_q + (AW+1)'(1);
      else if (!wr_en && pop) level_d = level_q - (AW+1)'(1);
      ovf_d  = (ovf_q  && !err_clr) || drop;
      ferr_d = (ferr_q && !err_clr) || ferr;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
         ferr_q   <= ferr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= {push_tag, push_last, rd_data_in};
   end

   // Outputs are forced to zero whenever the buffer is empty, including during reset.
   assign rd_valid   = (level_q != '0);
   assign {rd_tag, rd_last, rd_data} = rd_valid ? mem_q[rd_ptr_q] : '0;
   assign fifo_level = level_q;
   assign overflow   = ovf_q;
   assign frame_err  = ferr_q;

`ifdef DDR3_RDCAP_ERRCNT_EN
   logic [7:0] ecnt_q, ecnt_d;

   always_comb begin
      ecnt_d = err_clr ? 8'd0 : ecnt_q;
      if ((ferr || drop) && (ecnt_d != 8'hFF)) ecnt_d = ecnt_d + 8'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ecnt_q <= 8'd0;
      else     ecnt_q <= ecnt_d;
   end

   assign err_cnt = ecnt_q;
`else
   assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_ddr3_rd_capture.sv
// Directed bench for ddr3_rd_capture: vector table plus overflow and reset sequences.
module tb_ddr3_rd_capture;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  strobe_in;
   logic [31:0] rd_data_in;
   logic        rd_valid, rd_ready, rd_tag, rd_last;
   logic [31:0] rd_data;
   logic [3:0]  fifo_level;
   logic        overflow, frame_err, err_clr;
   logic [7:0]  err_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   ddr3_rd_capture #(.DW(32), .FIFO_DEPTH(8), .MAX_BEATS(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .strobe_in  (strobe_in),
      .rd_data_in (rd_data_in),
      .rd_valid   (rd_valid),
      .rd_ready   (rd_ready),
      .rd_data    (rd_data),
      .rd_tag     (rd_tag),
      .rd_last    (rd_last),
      .fifo_level (fifo_level),
      .overflow   (overflow),
      .frame_err  (frame_err),
      .err_clr    (err_clr),
      .err_cnt    (err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  st;
      logic [31:0] d;
      logic        rdy;
      logic        clr;
      logic        v;
      logic [31:0] q;
      logic        tag;
      logic        last;
      logic [3:0]  lvl;
      logic        ovf;
      logic        ferr;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(logic [3:0] st, logic [31:0] d, logic rdy, logic clr,
                               logic v, logic [31:0] q, logic tag, logic last,
                               logic [3:0] lvl, logic ovf, logic ferr);
      vec_t r;
      r.st = st; r.d = d; r.rdy = rdy; r.clr = clr;
      r.v = v; r.q = q; r.tag = tag; r.last = last;
      r.lvl = lvl; r.ovf = ovf; r.ferr = ferr;
      tbl.push_back(r);
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step(logic [3:0] st, logic [31:0] d, logic rdy, logic clr);
      @(negedge clk);
      strobe_in  = st;
      rd_data_in = d;
      rd_ready   = rdy;
      err_clr    = clr;
      @(posedge clk);
      #1;
   endtask

   logic [31:0] drain_exp [8];

   initial begin
      rst = 1'b1; strobe_in = 4'b0; rd_data_in = 32'd0; rd_ready = 1'b0; err_clr = 1'b0;
      #12;
      chk("reset rd_valid",   {31'd0, rd_valid}, 32'd0);
      chk("reset rd_data",    rd_data, 32'd0);
      chk("reset rd_tag",     {31'd0, rd_tag}, 32'd0);
      chk("reset rd_last",    {31'd0, rd_last}, 32'd0);
      chk("reset fifo_level", {28'd0, fifo_level}, 32'd0);
      chk("reset overflow",   {31'd0, overflow}, 32'd0);
      chk("reset frame_err",  {31'd0, frame_err}, 32'd0);
      chk("reset err_cnt",    {24'd0, err_cnt}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      //  st       data    rdy clr   v  q       tag last lvl ovf ferr
      add(4'b1011, 32'hA0, 1, 0,     1, 32'hA0, 1, 0, 4'd1, 0, 0);
      add(4'b0001, 32'hA1, 1, 0,     1, 32'hA1, 1, 0, 4'd1, 0, 0);
      add(4'b0001, 32'hA2, 1, 0,     1, 32'hA2, 1, 0, 4'd1, 0, 0);
      add(4'b0101, 32'hA3, 1, 0,     1, 32'hA3, 1, 1, 4'd1, 0, 0);
      add(4'b0000, 32'h0,  1, 0,     0, 32'h0,  0, 0, 4'd0, 0, 0);
      add(4'b0111, 32'h55, 1, 0,     1, 32'h55, 0, 1, 4'd1, 0, 0);
      add(4'b0000, 32'h0,  1, 0,     0, 32'h0,  0, 0, 4'd0, 0, 0);
      add(4'b0001, 32'h77, 1, 0,     0, 32'h0,  0, 0, 4'd0, 0, 1);
      add(4'b0000, 32'h0,  1, 1,     0, 32'h0,  0, 0, 4'd0, 0, 0);
      add(4'b1011, 32'hB0, 1, 0,     1, 32'hB0, 1, 0, 4'd1, 0, 0);
      add(4'b0011, 32'hB1, 1, 0,     1, 32'hB1, 0, 0, 4'd1, 0, 1);
      add(4'b0101, 32'hB2, 1, 0,     1, 32'hB2, 0, 1, 4'd1, 0, 1);
      add(4'b0000, 32'h0,  1, 1,     0, 32'h0,  0, 0, 4'd0, 0, 0);
      add(4'b0011, 32'hC0, 1, 0,     1, 32'hC0, 0, 0, 4'd1, 0, 0);
      add(4'b0001, 32'hC1, 1, 0,     1, 32'hC1, 0, 0, 4'd1, 0, 0);
      add(4'b0001, 32'hC2, 1, 0,     1, 32'hC2, 0, 0, 4'd1, 0, 0);
      add(4'b0001, 32'hC3, 1, 0,     1, 32'hC3, 0, 1, 4'd1, 0, 1);
      add(4'b0001, 32'hC4, 1, 0,     0, 32'h0,  0, 0, 4'd0, 0, 1);
      add(4'b0000, 32'h0,  1, 1,     0, 32'h0,  0, 0, 4'd0, 0, 0);
      add(4'b1110, 32'hE0, 1, 0,     0, 32'h0,  0, 0, 4'd0, 0, 0);
      add(4'b0001, 32'hE1, 1, 0,     0, 32'h0,  0, 0, 4'd0, 0, 1);
      add(4'b0000, 32'h0,  1, 1,     0, 32'h0,  0, 0, 4'd0, 0, 0);
      add(4'b1111, 32'hD0, 0, 0,     1, 32'hD0, 1, 1, 4'd1, 0, 0);
      add(4'b0000, 32'h0,  0, 0,     1, 32'hD0, 1, 1, 4'd1, 0, 0);
      add(4'b0000, 32'h0,  1, 0,     0, 32'h0,  0, 0, 4'd0, 0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].st, tbl[i].d, tbl[i].rdy, tbl[i].clr);
         chk($sformatf("vec%0d rd_valid", i),   {31'd0, rd_valid},   {31'd0, tbl[i].v});
         chk($sformatf("vec%0d rd_data", i),    rd_data,             tbl[i].q);
         chk($sformatf("vec%0d rd_tag", i),     {31'd0, rd_tag},     {31'd0, tbl[i].tag});
         chk($sformatf("vec%0d rd_last", i),    {31'd0, rd_last},    {31'd0, tbl[i].last});
         chk($sformatf("vec%0d fifo_level", i), {28'd0, fifo_level}, {28'd0, tbl[i].lvl});
         chk($sformatf("vec%0d overflow", i),   {31'd0, overflow},   {31'd0, tbl[i].ovf});
         chk($sformatf("vec%0d frame_err", i),  {31'd0, frame_err},  {31'd0, tbl[i].ferr});
      end

      // Fill the buffer with single-beat bursts, then one more beat to overflow.
      for (int i = 0; i < 8; i++) step(4'b0111, 32'h100 + i, 1'b0, 1'b0);
      chk("full level",    {28'd0, fifo_level}, 32'd8);
      chk("full overflow", {31'd0, overflow}, 32'd0);
      step(4'b0111, 32'h108, 1'b0, 1'b0);
      chk("ovf level",     {28'd0, fifo_level}, 32'd8);
      chk("ovf overflow",  {31'd0, overflow}, 32'd1);
`ifdef DDR3_RDCAP_ERRCNT_EN
      chk("ovf err_cnt",   {24'd0, err_cnt}, 32'd1);
`else
      chk("ovf err_cnt",   {24'd0, err_cnt}, 32'd0);
`endif
      step(4'b0000, 32'h0, 1'b0, 1'b1);
      chk("clr overflow",  {31'd0, overflow}, 32'd0);
      chk("clr err_cnt",   {24'd0, err_cnt}, 32'd0);
      step(4'b0111, 32'h200, 1'b1, 1'b0);
      chk("pp level",      {28'd0, fifo_level}, 32'd8);
      chk("pp overflow",   {31'd0, overflow}, 32'd0);
      for (int j = 0; j < 7; j++) drain_exp[j] = 32'h101 + j;
      drain_exp[7] = 32'h200;
      for (int j = 0; j < 8; j++) begin
         chk($sformatf("drain%0d rd_data", j), rd_data, drain_exp[j]);
         chk($sformatf("drain%0d level", j), {28'd0, fifo_level}, 32'(8 - j));
         step(4'b0000, 32'h0, 1'b1, 1'b0);
      end
      chk("drained level",    {28'd0, fifo_level}, 32'd0);
      chk("drained rd_valid", {31'd0, rd_valid}, 32'd0);

      // Reset mid-burst with two beats buffered, then the tail of the burst.
      step(4'b1011, 32'hE0, 1'b0, 1'b0);
      step(4'b0001, 32'hE1, 1'b0, 1'b0);
      chk("pre-rst level", {28'd0, fifo_level}, 32'd2);
      rst = 1'b1;
      #1;
      chk("mid-rst level",    {28'd0, fifo_level}, 32'd0);
      chk("mid-rst rd_valid", {31'd0, rd_valid}, 32'd0);
      chk("mid-rst rd_data",  rd_data, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      step(4'b0001, 32'hE2, 1'b1, 1'b0);
      chk("post-rst b3 frame_err", {31'd0, frame_err}, 32'd1);
      chk("post-rst b3 rd_valid",  {31'd0, rd_valid}, 32'd0);
      step(4'b0101, 32'hE3, 1'b1, 1'b0);
      chk("post-rst b4 rd_valid",  {31'd0, rd_valid}, 32'd0);
      chk("post-rst b4 level",     {28'd0, fifo_level}, 32'd0);
      chk("post-rst b4 frame_err", {31'd0, frame_err}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ddr3_rd_capture.md
DDR3_RD_CAPTURE -- requirements
Module: ddr3_rd_capture

Interface
REQ-001 SHALL have parameter DW, default 32: width of one captured read-data beat.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: output buffer depth in beats; power of two, 2 or more.
REQ-003 SHALL have parameter MAX_BEATS, default 4: maximum beats per burst; 1 to 16.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic rising-edge.
REQ-005 SHALL have port rst, input, 1: asynchronous reset, active-high.
REQ-006 SHALL have port strobe_in, input, 4: delayed read-strobe vector from the read-latency shift register.
  - [0] beat valid
  - [1] first beat of burst
  - [2] last beat of burst
  - [3] read tag
REQ-007 SHALL have port rd_data_in, input, DW: read-data beat, aligned to strobe_in in the same cycle.
REQ-008 SHALL have port rd_valid, output, 1: a beat is presented on rd_data.
REQ-009 SHALL have port rd_ready, input, 1: consumer accepts the presented beat.
REQ-010 SHALL have port rd_data, output, DW: buffered read-data beat.
REQ-011 SHALL have port rd_tag, output, 1: tag of the burst that owns the presented beat.
REQ-012 SHALL have port rd_last, output, 1: the presented beat closes its burst.
REQ-013 SHALL have port fifo_level, output, log2(FIFO_DEPTH)+1: number of beats held.
REQ-014 SHALL have port overflow, output, 1: sticky flag, a beat was dropped because the buffer was full.
REQ-015 SHALL have port frame_err, output, 1: sticky flag, a strobe framing violation occurred.
REQ-016 SHALL have port err_clr, input, 1: synchronous clear of overflow and frame_err.
REQ-017 SHALL have port err_cnt, output, 8: error counter (see Configuration).

Function
REQ-018 SHALL implement a framer FSM with states IDLE and BURST, plus a beat counter and a latched tag.
REQ-019 In IDLE, on valid=1 and first=1, SHALL push the beat and latch tag=strobe_in[3].
  - If last=1 in the same cycle: stay in IDLE.
  - Otherwise: go to BURST with beat count 1.
REQ-020 In IDLE, on valid=1 and first=0, SHALL drop the beat, set frame_err and stay in IDLE.
REQ-021 In BURST, on valid=1 and first=0, SHALL push the beat with the latched tag and increment the count.
  - Return to IDLE when last=1.
REQ-022 In BURST, on valid=1 and first=1, SHALL set frame_err and restart the burst: push the beat as a first beat and relatch the tag.
REQ-023 In BURST, when a non-last beat would bring the count to MAX_BEATS, SHALL push it marked rd_last=1, set frame_err and return to IDLE.
REQ-024 When valid=0, strobe bits [3:1] SHALL be ignored and no state SHALL change.
REQ-025 The buffer SHALL be a FIFO of {tag, last, data}; a beat pushed at cycle N SHALL appear on the outputs with rd_valid=1 at N+1 when the buffer was empty.
REQ-026 A pop SHALL occur when rd_valid=1 and rd_ready=1; rd_data, rd_tag and rd_last SHALL hold stable while rd_valid=1 and rd_ready=0.
REQ-027 A push to a full buffer SHALL be accepted only if a pop occurs in the same cycle; otherwise the beat SHALL be dropped and overflow set.
  - The framer FSM advances normally either way.
REQ-028 Simultaneous push and pop SHALL leave fifo_level unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-029 When err_clr=1 and a new error occur in the same cycle, the flag SHALL end set (set wins).
REQ-030 The block SHALL never stall upstream: read-data return has fixed latency and there is no ready toward the strobe source.

Reset
REQ-031 While rst=1, the block SHALL asynchronously force:
  - state=IDLE, beat count=0, latched tag=0
  - FIFO pointers=0, fifo_level=0
  - rd_valid=0, rd_data=0, rd_tag=0, rd_last=0
  - overflow=0, frame_err=0, err_cnt=0
REQ-032 Reset asserted mid-burst SHALL discard all buffered beats; after release the FSM SHALL require a fresh first beat.

Configuration
REQ-033 With macro DDR3_RDCAP_ERRCNT_EN defined, err_cnt SHALL be an 8-bit counter that:
  - increments once per cycle in which any frame error or overflow drop occurs
  - saturates at 255
  - clears on err_clr
REQ-034 Without DDR3_RDCAP_ERRCNT_EN, err_cnt SHALL be constant 0, and no counter logic SHALL be built.

Verification
REQ-035 Burst of 4 beats, first on beat 0, last on beat 3, tag=1, rd_ready=1, data A0..A3 -> outputs A0..A3 on cycles N+1..N+4, rd_tag=1, rd_last=1 only on A3, fifo_level never above 1.
REQ-036 Single beat with first=1, last=1 and data 0x55 -> one output 0x55 with rd_last=1, FSM in IDLE the next cycle.
REQ-037 rd_ready=0, push 9 beats with FIFO_DEPTH=8 -> fifo_level=8, overflow=1, the 9th beat absent when drained; err_cnt=1 with the macro defined, 0 without.
REQ-038 valid beat with first=0 in IDLE -> frame_err=1, beat dropped; err_clr=1 for one cycle -> frame_err=0.
REQ-039 Buffer full, push and pop in the same cycle -> push accepted, overflow stays 0, fifo_level stays 8.
REQ-040 rst pulsed after beat 2 of a 4-beat burst, then beats 3..4 arrive without a first beat -> beats dropped, frame_err=1, rd_valid=0.
